// File: rtl/axis_pkg.sv
// axis_pkg: shared AXI-Stream width defaults and helper functions.
package axis_pkg;
    localparam int AXIS_R   = 8;
    localparam int AXIS_W_Y = 19;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/axis_vec_serializer.sv
// axis_vec_serializer: splits one wide R-word AXI-Stream beat into R/K narrow beats of K words.
module axis_vec_serializer
    import axis_pkg::*;
#(
    parameter int R   = AXIS_R,
    parameter int W_Y = AXIS_W_Y,
    parameter int K   = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [R*W_Y-1:0]     s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [K*W_Y-1:0]     m_data,
    output logic                 m_last
);
    localparam int BUS_IN_W  = R * W_Y;
    localparam int BUS_OUT_W = K * W_Y;
    localparam int N_BEATS   = R / K;
    localparam int CNT_W     = clog2_min1(N_BEATS);

    if (R % K != 0) begin : g_bad_k
        $fatal(1, "axis_vec_serializer: R must be a multiple of K");
    end

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BUS_IN_W-1:0] vec_q, vec_d;
    logic                last_beat, take, fire;

    // s_ready is gated by rstn so nothing is offered while held in reset
    always_comb begin
        last_beat = cnt_q == CNT_W'(N_BEATS - 1);
        m_valid   = state_q == SEND;
        m_last    = m_valid && last_beat;
        m_data    = m_valid ? vec_q[int'(cnt_q) * BUS_OUT_W +: BUS_OUT_W] : '0;
        s_ready   = rstn && (state_q == IDLE || (m_ready && last_beat));
        take      = s_valid && s_ready;
        fire      = m_valid && m_ready;
        state_d   = take ? SEND : (fire && last_beat) ? IDLE : state_q;
        cnt_d     = take ? '0 : fire ? (last_beat ? '0 : cnt_q + CNT_W'(1)) : cnt_q;
        vec_d     = take ? s_data : vec_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
        end
    end
endmodule

// File: tb/tb_axis_vec_serializer.sv
// tb_axis_vec_serializer: randomized and directed checks against a beat-queue reference model.
module tb_axis_vec_serializer;
    localparam int R = 8, W_Y = 19, K = 2;
    localparam int BI = R * W_Y, BO = K * W_Y, NB = R / K;
    localparam int PROB_VALID = 10, PROB_READY = 10;

    typedef struct {
        logic          last;
        logic [BO-1:0] data;
        int            cyc;
    } beat_t;

    logic          clk = 0, rstn = 0, s_valid = 0, m_ready = 0;
    logic [BI-1:0] s_data = '0;
    logic          s_ready, m_valid, m_last;
    logic [BO-1:0] m_data;

    int pass_cnt = 0, total_cnt = 0, cyc = 0, acc = 0, n_last = 0;
    beat_t q[$];
    beat_t got[$];

    axis_vec_serializer #(.R(R), .W_Y(W_Y), .K(K)) dut (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        else pass_cnt++;
    endtask

    function automatic logic [BI-1:0] mkvec(input logic [W_Y-1:0] base, input bit down);
        logic [BI-1:0] v;
        for (int i = 0; i < R; i++) v[i*W_Y +: W_Y] = down ? base - W_Y'(i) : base + W_Y'(i);
        return v;
    endfunction

    // Model: every accepted vector owes NB beats in word order; only the final owed beat may overlap an accept.
    always @(negedge clk) begin
        if (!rstn) begin
            q.delete();
            check("rst_m_valid", m_valid, 0);
            check("rst_m_last", m_last, 0);
            check("rst_m_data", m_data, 0);
            check("rst_s_ready", s_ready, 0);
        end else begin
            check("m_valid", m_valid, q.size() != 0);
            check("s_ready", s_ready, q.size() == 0 || (q.size() == 1 && m_ready));
            if (q.size() != 0 && m_valid) begin
                check("m_data", m_data, q[0].data);
                check("m_last", m_last, q[0].last);
            end
            if (m_valid && m_ready) begin
                got.push_back('{m_last, m_data, cyc});
                if (m_last) n_last++;
                if (q.size() != 0) void'(q.pop_front());
            end
            if (s_valid && s_ready) begin
                acc++;
                for (int b = 0; b < NB; b++) q.push_back('{b == NB - 1, s_data[b*BO +: BO], 0});
            end
        end
        cyc++;
    end

    task automatic wait_sready();
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_ready) break;
        end
        check("accept_timeout", i < 200, 1);
    endtask

    task automatic send(input logic [BI-1:0] v);
        s_valid = 1;
        s_data  = v;
        wait_sready();
        @(posedge clk); #1;
        s_valid = 0;
    endtask

    task automatic drain();
        m_ready = 1;
        for (int i = 0; i < 200 && q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("drain_timeout", q.size(), 0);
    endtask

    initial begin
        logic [BO-1:0] exp1 [4];
        logic [BI-1:0] va, vb, re;
        int l0;
        exp1 = '{{19'd2, 19'd1}, {19'd4, 19'd3}, {19'd6, 19'd5}, {19'd8, 19'd7}};
        va = mkvec(19'd1, 0);
        vb = mkvec(19'h7FFFF, 1);
        repeat (3) @(posedge clk);
        #1 rstn = 1;
        m_ready = 1;

        got.delete();
        send(va);
        drain();
        check("t1_beats", got.size(), 4);
        for (int k = 0; k < 4 && k < got.size(); k++) begin
            check("t1_data", got[k].data, exp1[k]);
            check("t1_last", got[k].last, k == 3);
        end

        got.delete();
        s_valid = 1; s_data = va;
        wait_sready();
        @(posedge clk); #1 s_data = vb;
        wait_sready();
        @(posedge clk); #1 s_valid = 0;
        drain();
        check("t2_beats", got.size(), 8);
        if (got.size() == 8) check("t2_no_gap", got[7].cyc - got[0].cyc, 7);

        got.delete();
        send(va);
        @(posedge clk); #1;
        @(posedge clk); #1 m_ready = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_stall_valid", m_valid, 1);
            check("t3_stall_data", m_data, {19'd6, 19'd5});
        end
        @(posedge clk); #1;
        drain();
        check("t3_beats", got.size(), 4);
        if (got.size() == 4) check("t3_beat2", got[2].data, {19'd6, 19'd5});

        got.delete();
        send(vb);
        drain();
        check("t4_beats", got.size(), 4);
        if (got.size() == 4) begin
            check("t4_beat0", got[0].data, {19'h7FFFE, 19'h7FFFF});
            for (int k = 0; k < 4; k++) re[k*BO +: BO] = got[k].data;
            check("t4_lo", re[63:0], vb[63:0]);
            check("t4_hi", re[BI-1:BI-64], vb[BI-1:BI-64]);
        end

        send(mkvec(19'h50, 0));
        @(posedge clk); #3 rstn = 0;
        #1;
        check("t5_async_valid", m_valid, 0);
        check("t5_async_last", m_last, 0);
        check("t5_async_data", m_data, 0);
        @(posedge clk); #1 rstn = 1;
        got.delete();
        send(mkvec(19'h100, 0));
        drain();
        check("t5_beats", got.size(), 4);
        if (got.size() != 0) check("t5_first", got[0].data, {19'h101, 19'h100});

        l0 = n_last;
        acc = 0;
        for (int c = 0; c < 60000 && acc < 500; c++) begin
            s_valid = $urandom_range(0, 99) < PROB_VALID;
            for (int i = 0; i < R; i++) s_data[i*W_Y +: W_Y] = W_Y'($urandom);
            m_ready = $urandom_range(0, 99) < PROB_READY;
            @(posedge clk); #1;
        end
        s_valid = 0;
        drain();
        check("soak_vectors", acc, 500);
        check("soak_last_count", n_last - l0, 500);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/axis_vec_serializer.md
Name: axis_vec_serializer

Overview:
- Downstream end of the matrix-vector multiplier output stream.
- Accepts one wide AXI-Stream beat holding R result words of W_Y bits each.
- Re-emits that vector as N_BEATS = R/K narrower AXI-Stream beats of K words each, with m_last on the final beat.
- Lets the wide R*W_Y result drive narrow buses and the multi-beat AXIS_Sink, with no throughput bubble between vectors.

Parameters:
- R, 8, words per input vector.
- W_Y, 19, bits per word (matches W_X+W_K+clog2(C) for the 8x8x8 multiplier).
- K, 2, words per output beat; R mod K must be 0, otherwise elaboration fails via $fatal.
- Derived localparams: BUS_IN_W = R*W_Y, BUS_OUT_W = K*W_Y, N_BEATS = R/K, CNT_W = max(1, clog2(N_BEATS)).

Ports:
- clk  in  1  single clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- s_valid  in  1  input vector valid.
- s_ready  out  1  input vector accepted when high together with s_valid.
- s_data  in  BUS_IN_W  packed [R-1:0][W_Y-1:0]; word 0 in the LSBs.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream ready.
- m_data  out  BUS_OUT_W  packed [K-1:0][W_Y-1:0].
- m_last  out  1  high on the final beat of each vector.

Behaviour:
- Reset (asynchronous assert, synchronous release): m_valid=0, m_last=0, m_data=0, beat counter=0, state=IDLE, s_ready=0 while rstn is low.
- s_ready depends only on state and m_ready; it never depends on s_valid.
- FSM states:
  - IDLE: s_ready=1, m_valid=0. On s_valid&&s_ready, capture s_data into a vector register, set cnt=0, go to SEND.
  - SEND: m_valid=1, m_data = words [cnt*K +: K] of the vector register, m_last = (cnt==N_BEATS-1).
- Handshake in SEND, on m_valid&&m_ready:
  - Not last beat: cnt++.
  - Last beat with s_valid=1: capture the new vector, cnt=0, stay in SEND. This gives back-to-back vectors with zero idle cycles.
  - Last beat with s_valid=0: go to IDLE.
- s_ready in SEND = m_ready && (cnt==N_BEATS-1). This is a combinational path from m_ready to s_ready.
- Latency: first beat is visible the cycle after input acceptance. Throughput is one vector per N_BEATS cycles when m_ready is held high.
- Beat order: beat 0 carries words 0..K-1, beat 1 carries words K..2K-1, and so on. Within a beat, word 0 of that beat is in the LSBs.
- No arithmetic: word bits pass through unchanged; sign is preserved bit-exactly.
- AXIS rule: once m_valid is high, m_data, m_last and m_valid stay stable until m_ready. m_ready low stalls cnt indefinitely.
- N_BEATS==1 (K==R): m_last is always 1 in SEND; the block acts as a one-deep register slice.
- s_valid dropping while s_ready is low has no effect; nothing is captured.
- Reset mid-vector: the partial vector is discarded, m_valid drops immediately (asynchronously), and no m_last is emitted for it.

Decomposition:
- Package axis_pkg holds:
  - the function clog2_min1(n) returning max(1,$clog2(n));
  - the typedef-generating convention for word vectors (a parameterised packed-array helper is not possible, so each module declares its own packed types locally).
- Register the widths' defaults (R, W_Y) as package constants shared with axis_matvec_mul benches.
- No sub-module: the vector register, counter and two-state FSM live in one module.

Test Plan (all cases use R=8, K=2, W_Y=19; input word i = i+1; sink PROB_READY per case):
- Single vector, m_ready=1 constant -> 4 beats on consecutive cycles: {2,1},{4,3},{6,5},{8,7} (upper word listed first); m_last only on beat 3; s_ready low in beats 0–2.
- Back-to-back: two vectors offered with s_valid held high, second vector words = 0x7FFFF-i -> 8 consecutive m_valid cycles with no gap; second vector accepted in the same cycle as the first vector's last handshake.
- Backpressure: m_ready low for 5 cycles at beat 2 -> m_data stays {6,5} and m_valid stays 1 for all 5 cycles; no duplicate or skipped beat afterwards.
- Negative values: word i = -(i+1) in 19-bit two's complement (0x7FFFF, 0x7FFFE, ...) -> emitted bits are identical to the input; reassembled vector equals input.
- Reset at beat 1 -> m_valid=0 in the same cycle; after release, first output beat is word 0/1 of the next new vector.
- Random soak: 500 vectors, PROB_VALID=10, PROB_READY=10, scoreboard queue through the N_BEATS=4 sink -> all vectors match; m_last count = 500.
